// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: the memory-to-write-back bus layout and the
// helpers used to decode it.
package pipe_pkg;

    localparam int unsigned MS_TO_WS_BUS_W = 70;
    localparam int unsigned REG_ADDR_W     = 5;
    localparam int unsigned BUS_PC_W       = 32;
    localparam int unsigned BUS_DATA_W     = 32;

    // Field offsets inside the flat bus, LSB first.
    localparam int unsigned RESULT_LSB = 0;
    localparam int unsigned DEST_LSB   = RESULT_LSB + BUS_DATA_W;
    localparam int unsigned GR_WE_LSB  = DEST_LSB + REG_ADDR_W;
    localparam int unsigned PC_LSB     = GR_WE_LSB + 1;

    typedef struct packed {
        logic [BUS_PC_W-1:0]   pc;
        logic                  gr_we;
        logic [REG_ADDR_W-1:0] dest;
        logic [BUS_DATA_W-1:0] result;
    } ms_to_ws_bus_t;

    function automatic ms_to_ws_bus_t unpack_ms_to_ws(input logic [MS_TO_WS_BUS_W-1:0] raw);
        ms_to_ws_bus_t b;
        b.pc     = raw[PC_LSB +: BUS_PC_W];
        b.gr_we  = raw[GR_WE_LSB];
        b.dest   = raw[DEST_LSB +: REG_ADDR_W];
        b.result = raw[RESULT_LSB +: BUS_DATA_W];
        return b;
    endfunction

    // r0 is hardwired to zero, so it is never a real write target.
    function automatic logic writes_reg(input ms_to_ws_bus_t b);
        return b.gr_we & (b.dest != '0);
    endfunction

endpackage

// File: rtl/wb_retire_counter.sv
// Free-running event counter with asynchronous clear; wraps silently.
module wb_retire_counter #(
    parameter int unsigned CNT_W = 64
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: one-entry valid/allowin register feeding the register file,
// the decode bypass and the retire counter. WB_DEBUG_TRACE_EN adds trace outputs.
module wb_stage
    import pipe_pkg::*;
#(
    parameter int unsigned PC_W   = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 64
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      ms_to_ws_valid,
    input  logic [MS_TO_WS_BUS_W-1:0] ms_to_ws_bus,
    output logic                      ws_allowin,
    input  logic                      wb_hold,
    output logic                      rf_we,
    output logic [REG_ADDR_W-1:0]     rf_waddr,
    output logic [DATA_W-1:0]         rf_wdata,
    output logic                      ws_fwd_valid,
    output logic [REG_ADDR_W-1:0]     ws_fwd_dest,
    output logic [DATA_W-1:0]         ws_fwd_data,
    output logic [CNT_W-1:0]          retire_cnt
`ifdef WB_DEBUG_TRACE_EN
    ,
    output logic [PC_W-1:0]           debug_wb_pc,
    output logic [3:0]                debug_wb_rf_we,
    output logic [REG_ADDR_W-1:0]     debug_wb_rf_wnum,
    output logic [DATA_W-1:0]         debug_wb_rf_wdata
`endif
);

    logic          r_ws_valid;
    ms_to_ws_bus_t r_ws_bus;

    logic w_ready_go;
    logic w_retire;
    logic w_writes_reg;

    assign w_ready_go = ~wb_hold;
    assign ws_allowin = ~r_ws_valid | w_ready_go;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ws_valid <= 1'b0;
            r_ws_bus   <= '0;
        end else begin
            if (ws_allowin) begin
                r_ws_valid <= ms_to_ws_valid;
            end
            if (ms_to_ws_valid && ws_allowin) begin
                r_ws_bus <= unpack_ms_to_ws(ms_to_ws_bus);
            end
        end
    end

    assign w_retire     = r_ws_valid & w_ready_go;
    assign w_writes_reg = writes_reg(r_ws_bus);

    assign rf_we    = w_retire & w_writes_reg;
    assign rf_waddr = r_ws_bus.dest;
    assign rf_wdata = r_ws_bus.result;

    // Bypass ignores the hold so decode still sees a stalled result.
    assign ws_fwd_valid = r_ws_valid & w_writes_reg;
    assign ws_fwd_dest  = r_ws_bus.dest;
    assign ws_fwd_data  = r_ws_bus.result;

    wb_retire_counter #(
        .CNT_W(CNT_W)
    ) u_retire_counter (
        .clk   (clk),
        .resetn(resetn),
        .inc   (w_retire),
        .count (retire_cnt)
    );

`ifdef WB_DEBUG_TRACE_EN
    assign debug_wb_pc       = r_ws_bus.pc;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = r_ws_bus.dest;
    assign debug_wb_rf_wdata = r_ws_bus.result;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed vector table, reset/wrap sequences
// and randomized traffic against a slot-based reference model.
module tb_wb_stage;
    import pipe_pkg::*;

    logic                      clk;
    logic                      resetn;
    logic                      in_valid;
    ms_to_ws_bus_t             in_bus;
    logic                      in_hold;

    logic                      ws_allowin, rf_we, ws_fwd_valid;
    logic [4:0]                rf_waddr, ws_fwd_dest;
    logic [31:0]               rf_wdata, ws_fwd_data;
    logic [63:0]               retire_cnt;

    logic                      s_allowin, s_rf_we, s_fwd_valid;
    logic [4:0]                s_waddr, s_fwd_dest;
    logic [31:0]               s_wdata, s_fwd_data;
    logic [3:0]                s_cnt;

`ifdef WB_DEBUG_TRACE_EN
    logic [31:0] dbg_pc, dbg_wdata, s_dbg_pc, s_dbg_wdata;
    logic [3:0]  dbg_we, s_dbg_we;
    logic [4:0]  dbg_wnum, s_dbg_wnum;
`endif

    wb_stage dut (
        .clk           (clk),
        .resetn        (resetn),
        .ms_to_ws_valid(in_valid),
        .ms_to_ws_bus  (in_bus),
        .ws_allowin    (ws_allowin),
        .wb_hold       (in_hold),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .ws_fwd_valid  (ws_fwd_valid),
        .ws_fwd_dest   (ws_fwd_dest),
        .ws_fwd_data   (ws_fwd_data),
        .retire_cnt    (retire_cnt)
`ifdef WB_DEBUG_TRACE_EN
        ,
        .debug_wb_pc      (dbg_pc),
        .debug_wb_rf_we   (dbg_we),
        .debug_wb_rf_wnum (dbg_wnum),
        .debug_wb_rf_wdata(dbg_wdata)
`endif
    );

    // Narrow-counter copy sharing all inputs, to exercise wrap-around.
    wb_stage #(
        .CNT_W(4)
    ) dut_small (
        .clk           (clk),
        .resetn        (resetn),
        .ms_to_ws_valid(in_valid),
        .ms_to_ws_bus  (in_bus),
        .ws_allowin    (s_allowin),
        .wb_hold       (in_hold),
        .rf_we         (s_rf_we),
        .rf_waddr      (s_waddr),
        .rf_wdata      (s_wdata),
        .ws_fwd_valid  (s_fwd_valid),
        .ws_fwd_dest   (s_fwd_dest),
        .ws_fwd_data   (s_fwd_data),
        .retire_cnt    (s_cnt)
`ifdef WB_DEBUG_TRACE_EN
        ,
        .debug_wb_pc      (s_dbg_pc),
        .debug_wb_rf_we   (s_dbg_we),
        .debug_wb_rf_wnum (s_dbg_wnum),
        .debug_wb_rf_wdata(s_dbg_wdata)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic ms_to_ws_bus_t mk(input logic [31:0] pc, input logic we,
                                         input logic [4:0] dest, input logic [31:0] res);
        ms_to_ws_bus_t b;
        b.pc = pc; b.gr_we = we; b.dest = dest; b.result = res;
        return b;
    endfunction

    // Directed vectors: inputs applied this cycle, outputs expected in the same cycle.
    typedef struct {
        logic          valid;
        ms_to_ws_bus_t bus;
        logic          hold;
        logic          e_we;
        logic          e_fwd;
        logic          e_allow;
        logic [4:0]    e_dest;
        logic [31:0]   e_data;
        logic [63:0]   e_cnt;
    } vec_t;

    vec_t vecs[19];

    // Reference model: the stage is a slot that is full or empty.
    logic          m_full;
    ms_to_ws_bus_t m_last;
    logic [63:0]   m_cnt;

    task automatic mcycle(input logic v, input ms_to_ws_bus_t b, input logic h);
        logic e_fwd, e_we, e_allow;
        in_valid = v; in_bus = b; in_hold = h;
        @(negedge clk);
        e_fwd   = m_full && m_last.gr_we && (m_last.dest != 5'd0);
        e_we    = e_fwd && !h;
        e_allow = !m_full || !h;
        chk("m_allowin", {63'd0, ws_allowin}, {63'd0, e_allow});
        chk("m_rf_we", {63'd0, rf_we}, {63'd0, e_we});
        chk("m_fwd_valid", {63'd0, ws_fwd_valid}, {63'd0, e_fwd});
        if (e_we) begin
            chk("m_waddr", {59'd0, rf_waddr}, {59'd0, m_last.dest});
            chk("m_wdata", {32'd0, rf_wdata}, {32'd0, m_last.result});
        end
        if (e_fwd) begin
            chk("m_fwd_dest", {59'd0, ws_fwd_dest}, {59'd0, m_last.dest});
            chk("m_fwd_data", {32'd0, ws_fwd_data}, {32'd0, m_last.result});
        end
        chk("m_cnt", retire_cnt, m_cnt);
        chk("m_cnt4", {60'd0, s_cnt}, {60'd0, m_cnt[3:0]});
`ifdef WB_DEBUG_TRACE_EN
        chk("m_dbg_we", {60'd0, dbg_we}, {60'd0, {4{e_we}}});
        if (m_full) chk("m_dbg_pc", {32'd0, dbg_pc}, {32'd0, m_last.pc});
`endif
        @(posedge clk);
        if (e_allow) begin
            if (m_full) m_cnt = m_cnt + 64'd1;
            m_full = v;
            if (v) m_last = b;
        end
        #1;
    endtask

    initial begin
        ms_to_ws_bus_t b;
        // Directed table
        vecs[0] = '{1'b1, mk(32'hBFC00000, 1'b1, 5'd5, 32'h12345678), 1'b0,
                    1'b0, 1'b0, 1'b1, 5'd0, 32'h0, 64'd0};
        vecs[1] = '{1'b1, mk(32'hBFC00004, 1'b1, 5'd0, 32'hFFFFFFFF), 1'b0,
                    1'b1, 1'b1, 1'b1, 5'd5, 32'h12345678, 64'd0};
        vecs[2] = '{1'b1, mk(32'hBFC00008, 1'b1, 5'd7, 32'h000000A5), 1'b0,
                    1'b0, 1'b0, 1'b1, 5'd0, 32'h0, 64'd1};
        for (int i = 3; i < 6; i++) begin
            vecs[i] = '{1'b1, mk(32'hBFC0000C, 1'b1, 5'd9, 32'h0000BEEF), 1'b1,
                        1'b0, 1'b1, 1'b0, 5'd7, 32'h000000A5, 64'd2};
        end
        vecs[6] = '{1'b1, mk(32'hBFC0000C, 1'b1, 5'd9, 32'h0000BEEF), 1'b0,
                    1'b1, 1'b1, 1'b1, 5'd7, 32'h000000A5, 64'd2};
        vecs[7] = '{1'b0, mk(32'h0, 1'b0, 5'd0, 32'h0), 1'b0,
                    1'b1, 1'b1, 1'b1, 5'd9, 32'h0000BEEF, 64'd3};
        vecs[8] = '{1'b0, mk(32'h0, 1'b0, 5'd0, 32'h0), 1'b0,
                    1'b0, 1'b0, 1'b1, 5'd0, 32'h0, 64'd4};
        for (int j = 1; j <= 8; j++) begin
            vecs[8 + j] = '{1'b1, mk(32'h1000 + 32'(j * 4), 1'b1, 5'(j), 32'(j * 32'h111)), 1'b0,
                            (j > 1), (j > 1), 1'b1, 5'(j - 1), 32'((j - 1) * 32'h111),
                            64'(4 + ((j > 1) ? j - 2 : 0))};
        end
        vecs[17] = '{1'b0, mk(32'h0, 1'b0, 5'd0, 32'h0), 1'b0,
                     1'b1, 1'b1, 1'b1, 5'd8, 32'(8 * 32'h111), 64'd11};
        vecs[18] = '{1'b0, mk(32'h0, 1'b0, 5'd0, 32'h0), 1'b0,
                     1'b0, 1'b0, 1'b1, 5'd0, 32'h0, 64'd12};

        // Reset
        resetn = 1'b0; in_valid = 1'b0; in_bus = '0; in_hold = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rf_we", {63'd0, rf_we}, 64'd0);
        chk("rst_fwd_valid", {63'd0, ws_fwd_valid}, 64'd0);
        chk("rst_waddr", {59'd0, rf_waddr}, 64'd0);
        chk("rst_wdata", {32'd0, rf_wdata}, 64'd0);
        chk("rst_cnt", retire_cnt, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 19; i++) begin
            in_valid = vecs[i].valid; in_bus = vecs[i].bus; in_hold = vecs[i].hold;
            @(negedge clk);
            chk($sformatf("v%0d_rf_we", i), {63'd0, rf_we}, {63'd0, vecs[i].e_we});
            chk($sformatf("v%0d_fwd", i), {63'd0, ws_fwd_valid}, {63'd0, vecs[i].e_fwd});
            chk($sformatf("v%0d_allow", i), {63'd0, ws_allowin}, {63'd0, vecs[i].e_allow});
            chk($sformatf("v%0d_cnt", i), retire_cnt, vecs[i].e_cnt);
            if (vecs[i].e_we) begin
                chk($sformatf("v%0d_waddr", i), {59'd0, rf_waddr}, {59'd0, vecs[i].e_dest});
                chk($sformatf("v%0d_wdata", i), {32'd0, rf_wdata}, {32'd0, vecs[i].e_data});
            end
            if (vecs[i].e_fwd) begin
                chk($sformatf("v%0d_fdest", i), {59'd0, ws_fwd_dest}, {59'd0, vecs[i].e_dest});
                chk($sformatf("v%0d_fdata", i), {32'd0, ws_fwd_data}, {32'd0, vecs[i].e_data});
            end
            @(posedge clk);
            #1;
        end

        m_full = 1'b0; m_cnt = 64'd12; m_last = vecs[16].bus;

        // Reset mid-operation
        mcycle(1'b1, mk(32'h2000, 1'b1, 5'd3, 32'h33), 1'b0);
        in_valid = 1'b0;
        chk("mid_inflight_we", {63'd0, rf_we}, 64'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("mid_rst_rf_we", {63'd0, rf_we}, 64'd0);
        chk("mid_rst_fwd", {63'd0, ws_fwd_valid}, 64'd0);
        chk("mid_rst_cnt", retire_cnt, 64'd0);
        chk("mid_rst_cnt4", {60'd0, s_cnt}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        m_full = 1'b0; m_cnt = 64'd0; m_last = '0;
        mcycle(1'b0, '0, 1'b0);
        mcycle(1'b0, '0, 1'b0);

        // Counter wrap on the 4-bit instance: 17 retires
        for (int k = 0; k < 17; k++) begin
            mcycle(1'b1, mk(32'h3000 + 32'(k), 1'(k), 5'(k), 32'(k)), 1'b0);
        end
        mcycle(1'b0, '0, 1'b0);
        chk("wrap_cnt4", {60'd0, s_cnt}, 64'd1);
        chk("wrap_cnt64", retire_cnt, 64'd17);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            b = mk($urandom, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
            mcycle($urandom_range(0, 3) != 0, b, $urandom_range(0, 3) == 0);
        end
        mcycle(1'b0, '0, 1'b0);
        mcycle(1'b0, '0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
